// File: rtl/sie_piso_serializer.sv
// rtl/sie_piso_serializer.sv - SIE transmit parallel-to-serial shifter with optional bit stuffing
//
// Purpose:
//   Takes words from the packet byte source over a valid/ready handshake and
//   shifts them out one bit per bit_en strobe towards the NRZI encoder. A
//   one-word holding buffer keeps consecutive words gap-free. When STUFF_EN
//   is set, a 0 is inserted after STUFF_RUN consecutive emitted ones.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   bit_en     bit-slot strobe; one bit is emitted per edge with bit_en=1
//   in_data    word to transmit
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle (holding buffer empty)
//   ser_out    registered serial bit
//   ser_valid  ser_out holds a transmitted bit (data or stuff)
//   word_done  one-cycle pulse on the edge that registers a word's final data bit
//   busy       a word is in flight or waiting in the holding buffer

module sie_piso_serializer #(
   parameter int DATA_W    = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter bit STUFF_EN  = 1'b1,
   parameter int STUFF_RUN = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_en,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              word_done,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STUFF = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] sh, sh_nxt;
   logic [DATA_W-1:0] hold, hold_nxt;
   logic              hold_full, hold_full_nxt;
   logic [CNT_W-1:0]  bits_left, bits_left_nxt;
   logic [3:0]        run, run_nxt;
   logic              ser_out_nxt, ser_valid_nxt, word_done_nxt;

   logic              accept;
   logic              need_word;
   logic              tx_bit;
   logic [DATA_W-1:0] sh_shifted;
   logic [3:0]        run_inc;
   logic              last_bit;

   assign in_ready = !hold_full;
   assign busy     = (state != IDLE) || hold_full;
   assign accept   = in_valid && in_ready;

   assign tx_bit     = LSB_FIRST ? sh[0] : sh[DATA_W-1];
   assign sh_shifted = LSB_FIRST ? {1'b0, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], 1'b0};
   assign run_inc    = tx_bit ? (run + 4'd1) : 4'd0;
   assign last_bit   = (bits_left == CNT_W'(1));

   always_comb begin
      state_nxt     = state;
      sh_nxt        = sh;
      bits_left_nxt = bits_left;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      run_nxt       = run;
      ser_out_nxt   = ser_out;
      ser_valid_nxt = ser_valid;
      word_done_nxt = 1'b0;
      need_word     = 1'b0;

      // Bit-slot actions: only on strobed edges.
      if (bit_en) begin
         case (state)
            IDLE: begin
               // An idle slot breaks the ones run seen by the receiver.
               ser_out_nxt   = 1'b0;
               ser_valid_nxt = 1'b0;
               run_nxt       = 4'd0;
            end
            SHIFT: begin
               sh_nxt        = sh_shifted;
               ser_out_nxt   = tx_bit;
               ser_valid_nxt = 1'b1;
               bits_left_nxt = bits_left - CNT_W'(1);
               run_nxt       = run_inc;
               word_done_nxt = last_bit;
               // A pending stuff bit goes out before the next word is fetched.
               if (STUFF_EN && (run_inc == 4'(STUFF_RUN))) begin
                  state_nxt = STUFF;
               end else if (last_bit) begin
                  need_word = 1'b1;
               end
            end
            STUFF: begin
               ser_out_nxt   = 1'b0;
               ser_valid_nxt = 1'b1;
               run_nxt       = 4'd0;
               if (bits_left != '0) begin
                  state_nxt = SHIFT;
               end else begin
                  need_word = 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end

      // Word intake: independent of bit_en.
      if (state == IDLE) begin
         if (accept) begin
            sh_nxt        = in_data;
            bits_left_nxt = CNT_W'(DATA_W);
            state_nxt     = SHIFT;
         end
      end else if (need_word) begin
         if (hold_full) begin
            // in_ready is low while hold is full, so nothing can be
            // accepted on this edge; hold simply drains into sh.
            sh_nxt        = hold;
            bits_left_nxt = CNT_W'(DATA_W);
            hold_full_nxt = 1'b0;
            state_nxt     = SHIFT;
         end else if (accept) begin
            sh_nxt        = in_data;
            bits_left_nxt = CNT_W'(DATA_W);
            state_nxt     = SHIFT;
         end else begin
            state_nxt     = IDLE;
         end
      end else if (accept) begin
         hold_nxt      = in_data;
         hold_full_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         sh        <= '0;
         bits_left <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         run       <= 4'd0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         word_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         sh        <= sh_nxt;
         bits_left <= bits_left_nxt;
         hold      <= hold_nxt;
         hold_full <= hold_full_nxt;
         run       <= run_nxt;
         ser_out   <= ser_out_nxt;
         ser_valid <= ser_valid_nxt;
         word_done <= word_done_nxt;
      end
   end

endmodule

// File: tb/tb_sie_piso_serializer.sv
// tb/tb_sie_piso_serializer.sv - self-checking bench for sie_piso_serializer

module tb_sie_piso_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset  = 1'b1;
   logic       bit_en = 1'b0;
   logic       en_last = 1'b0;
   int         en_div = 4;
   int         en_cnt = 0;

   logic [7:0] ab_data  = 8'h00;
   logic       ab_valid = 1'b0;
   logic [7:0] c_data   = 8'h00;
   logic       c_in_valid = 1'b0;

   logic a_in_ready, a_ser_out, a_ser_valid, a_word_done, a_busy;
   logic b_in_ready, b_ser_out, b_ser_valid, b_word_done, b_busy;
   logic c_in_ready, c_ser_out, c_ser_valid, c_word_done, c_busy;

   int   total = 0;
   int   bad   = 0;
   int   done_a = 0, done_b = 0, done_c = 0;
   bit   mon_c  = 1'b1;
   bit   saw_bp = 1'b0;

   logic q_a[$];
   logic q_b[$];
   logic q_c[$];

   typedef struct {
      logic [7:0] word;
      logic [7:0] exp_lsb;
      logic [7:0] exp_msb;
   } vec_t;
   vec_t tbl[6];

   sie_piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b1), .STUFF_EN(1'b0), .STUFF_RUN(6)) u_a (
      .clk(clk), .reset(reset), .bit_en(bit_en), .in_data(ab_data), .in_valid(ab_valid),
      .in_ready(a_in_ready), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
      .word_done(a_word_done), .busy(a_busy));

   sie_piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b0), .STUFF_EN(1'b0), .STUFF_RUN(6)) u_b (
      .clk(clk), .reset(reset), .bit_en(bit_en), .in_data(ab_data), .in_valid(ab_valid),
      .in_ready(b_in_ready), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
      .word_done(b_word_done), .busy(b_busy));

   sie_piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b1), .STUFF_EN(1'b1), .STUFF_RUN(6)) u_c (
      .clk(clk), .reset(reset), .bit_en(bit_en), .in_data(c_data), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .ser_out(c_ser_out), .ser_valid(c_ser_valid),
      .word_done(c_word_done), .busy(c_busy));

   always @(negedge clk) begin
      if (en_cnt >= en_div - 1) en_cnt = 0;
      else en_cnt = en_cnt + 1;
      bit_en = (en_cnt == 0);
   end

   always @(posedge clk) en_last <= bit_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired or unexpected bit", name);
   endtask

   // Scoreboard: pop one expected bit per registered serial bit.
   always @(negedge clk) begin
      logic e;
      if (reset) begin
         if (a_word_done) done_a++;
         if (b_word_done) done_b++;
         if (c_word_done) done_c++;
         if (ab_valid && !a_in_ready) saw_bp = 1'b1;
         if (en_last && a_ser_valid) begin
            if (q_a.size() == 0) flag("a_extra_bit");
            else begin e = q_a.pop_front(); chk("a_bit", 32'(a_ser_out), 32'(e)); end
         end
         if (en_last && b_ser_valid) begin
            if (q_b.size() == 0) flag("b_extra_bit");
            else begin e = q_b.pop_front(); chk("b_bit", 32'(b_ser_out), 32'(e)); end
         end
         if (mon_c && en_last && c_ser_valid) begin
            if (q_c.size() == 0) flag("c_extra_bit");
            else begin e = q_c.pop_front(); chk("c_bit", 32'(c_ser_out), 32'(e)); end
         end
      end
   end

   task automatic send_ab(input logic [7:0] w, input logic [7:0] ea, input logic [7:0] eb);
      bit ok = 1'b0;
      ab_data  = w;
      ab_valid = 1'b1;
      for (int t = 0; t < 400 && !ok; t++) begin
         if (a_in_ready && b_in_ready) begin
            for (int i = 7; i >= 0; i--) begin
               q_a.push_back(ea[i]);
               q_b.push_back(eb[i]);
            end
            ok = 1'b1;
         end
         @(negedge clk);
      end
      ab_valid = 1'b0;
      if (!ok) flag("ab_send_timeout");
   endtask

   task automatic send_c(input logic [7:0] w);
      bit ok = 1'b0;
      c_data     = w;
      c_in_valid = 1'b1;
      for (int t = 0; t < 400 && !ok; t++) begin
         if (c_in_ready) ok = 1'b1;
         @(negedge clk);
      end
      c_in_valid = 1'b0;
      if (!ok) flag("c_send_timeout");
   endtask

   task automatic push_c(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) q_c.push_back(bits[i]);
   endtask

   task automatic wait_idle_ab(input string name);
      bit ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         if (!a_busy && !b_busy && q_a.size() == 0 && q_b.size() == 0) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) flag(name);
      repeat (2 * en_div + 2) @(negedge clk);
   endtask

   task automatic wait_idle_c(input string name);
      bit ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         if (!c_busy && q_c.size() == 0) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) flag(name);
      repeat (3) @(negedge clk);
      chk({name, "_valid_low"}, 32'(c_ser_valid), 32'd0);
   endtask

   initial begin
      int d0, d1, cnt;

      tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
      tbl[1] = '{8'h01, 8'h80, 8'h01};
      tbl[2] = '{8'hC1, 8'h83, 8'hC1};
      tbl[3] = '{8'h6E, 8'h76, 8'h6E};
      tbl[4] = '{8'hF0, 8'h0F, 8'hF0};
      tbl[5] = '{8'h12, 8'h48, 8'h12};

      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a", 32'({a_ser_out, a_ser_valid, a_word_done, a_in_ready, a_busy}), 32'b00010);
      chk("rst_b", 32'({b_ser_out, b_ser_valid, b_word_done, b_in_ready, b_busy}), 32'b00010);
      chk("rst_c", 32'({c_ser_out, c_ser_valid, c_word_done, c_in_ready, c_busy}), 32'b00010);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Single words, bit_en every 4th clock, both bit orders.
      en_div = 4;
      foreach (tbl[k]) begin
         d0 = done_a;
         d1 = done_b;
         send_ab(tbl[k].word, tbl[k].exp_lsb, tbl[k].exp_msb);
         wait_idle_ab("ab_single_timeout");
         chk("a_done_once", 32'(done_a - d0), 32'd1);
         chk("b_done_once", 32'(done_b - d1), 32'd1);
         chk("ab_idle_after", 32'({a_ser_valid, a_busy, b_ser_valid, b_busy}), 32'd0);
      end

      // Backpressure: three words presented continuously, bit_en every 2nd clock.
      en_div = 2;
      repeat (4) @(negedge clk);
      saw_bp = 1'b0;
      d0 = done_a;
      for (int k = 0; k < 3; k++) send_ab(tbl[k].word, tbl[k].exp_lsb, tbl[k].exp_msb);
      wait_idle_ab("ab_bp_timeout");
      chk("bp_ready_dropped", 32'(saw_bp), 32'd1);
      chk("bp_done_count", 32'(done_a - d0), 32'd3);

      // Stuffing with back-to-back FF, 0F and bit_en high every clock.
      en_div = 1;
      repeat (4) @(negedge clk);
      push_c(32'b111111011111100000, 18);
      d0 = done_c;
      c_data     = 8'hFF;
      c_in_valid = 1'b1;
      chk("c_ready_idle", 32'(c_in_ready), 32'd1);
      @(negedge clk);
      chk("c_first_latency", 32'(c_ser_valid), 32'd0);
      c_data = 8'h0F;
      chk("c_ready_hold", 32'(c_in_ready), 32'd1);
      @(negedge clk);
      c_in_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 18; i++) begin
         if (c_ser_valid) cnt++;
         @(negedge clk);
      end
      chk("c_no_gap_slots", 32'(cnt), 32'd18);
      chk("c_stream_end", 32'(c_ser_valid), 32'd0);
      chk("c_done_twice", 32'(done_c - d0), 32'd2);
      chk("c_queue_drained", 32'(q_c.size()), 32'd0);

      // Run carried across contiguous words: F8 then 03 forces a stuff bit.
      push_c(32'b00011111101000000, 17);
      d0 = done_c;
      send_c(8'hF8);
      send_c(8'h03);
      wait_idle_c("c_carry");
      chk("c_carry_done", 32'(done_c - d0), 32'd2);

      // Same words separated by an idle slot: no stuff bit.
      push_c(32'b00011111, 8);
      send_c(8'hF8);
      wait_idle_c("c_gap_first");
      push_c(32'b11000000, 8);
      send_c(8'h03);
      wait_idle_c("c_gap_second");

      // 3F stuffs inside its own word; 03 after an idle slot does not.
      push_c(32'b111111000, 9);
      send_c(8'h3F);
      wait_idle_c("c_3f");
      push_c(32'b11000000, 8);
      send_c(8'h03);
      wait_idle_c("c_3f_03");

      // Reset mid-word with a word waiting in hold.
      mon_c = 1'b0;
      send_c(8'hFF);
      send_c(8'h0F);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid_c", 32'({c_ser_out, c_ser_valid, c_word_done, c_in_ready, c_busy}), 32'b00010);
      @(negedge clk);
      reset = 1'b1;
      q_c.delete();
      mon_c = 1'b1;
      @(negedge clk);
      push_c(32'b10000001, 8);
      d0 = done_c;
      send_c(8'h81);
      wait_idle_c("c_after_reset");
      chk("c_after_reset_done", 32'(done_c - d0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
